// File: rtl/carfield_chip_pkg.sv
// Shared Carfield chip types and defaults for the clock-configuration sequencers.
package carfield_chip_pkg;

    // Clock domain indices; also the bit position of each domain in the sequencer ports.
    typedef enum logic [1:0] {
        CLK_HOST   = 2'd0,
        CLK_PERIPH = 2'd1,
        CLK_ALT    = 2'd2,
        CLK_SECURE = 2'd3
    } carfield_clocks_e;

    localparam int unsigned DefaultNumDomains   = 4;
    localparam int unsigned DefaultNumPlls      = 3;
    localparam int unsigned DefaultGateCycles   = 8;
    localparam int unsigned DefaultSwitchCycles = 16;
    localparam int unsigned DefaultLockTimeout  = 4096;

    // Source encoding: 0 = reference bypass, p+1 = PLL p.
    localparam int unsigned ClkSrcW = $clog2(DefaultNumPlls + 1);
    typedef logic [ClkSrcW-1:0] clk_src_t;
    localparam clk_src_t RefClkSrc = '0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATE   = 3'd1,
        LOCK   = 3'd2,
        SWITCH = 3'd3,
        FAIL   = 3'd4,
        UNGATE = 3'd5
    } clk_seq_state_e;

endpackage

// File: rtl/carfield_clk_seq_rr.sv
// Round-robin arbiter: searches from the pointer, grants only while enabled,
// and moves the pointer just past the winner on every grant.
module carfield_clk_seq_rr
    import carfield_chip_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] ptr_reg;
    logic [IdxW-1:0] cand;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < int'(N); i++) begin
            cand = IdxW'((int'(ptr_reg) + i) % int'(N));
            if (en_i && !valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    // Pointer advances to the domain after the winner.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_reg <= '0;
        end else if (valid_o) begin
            ptr_reg <= (idx_o == IdxW'(N - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/carfield_clk_seq.sv
// Clock-source change sequencer for the Carfield clock domains: gate, lock,
// switch mux, ungate, one domain at a time with round-robin request service.
module carfield_clk_seq
    import carfield_chip_pkg::*;
#(
    parameter int unsigned NumDomains   = DefaultNumDomains,
    parameter int unsigned NumPlls      = DefaultNumPlls,
    parameter int unsigned GateCycles   = DefaultGateCycles,
    parameter int unsigned SwitchCycles = DefaultSwitchCycles,
    parameter int unsigned LockTimeout  = DefaultLockTimeout,
    localparam int unsigned SrcW        = $clog2(NumPlls + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumDomains-1:0]      req_valid_i,
    input  logic [NumDomains*SrcW-1:0] req_src_i,
    output logic [NumDomains-1:0]      req_ready_o,
    output logic [NumPlls-1:0]         pll_en_o,
    input  logic [NumPlls-1:0]         pll_lock_i,
    output logic [NumDomains-1:0]      clk_en_o,
    output logic [NumDomains*SrcW-1:0] clk_sel_o,
    output logic [NumDomains-1:0]      done_o,
    output logic [NumDomains-1:0]      err_o,
    output logic                       busy_o
);

    localparam int unsigned DomW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam int unsigned CntMax0 = (GateCycles > SwitchCycles) ? GateCycles : SwitchCycles;
    localparam int unsigned CntMax  = (CntMax0 > LockTimeout) ? CntMax0 : LockTimeout;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam logic [SrcW:0] MaxSrc = (SrcW + 1)'(NumPlls);

    clk_seq_state_e          state_reg;
    logic [DomW-1:0]         dom_reg;
    logic [SrcW-1:0]         src_reg;
    logic [CntW-1:0]         cnt_reg;
    logic [CntW-1:0]         cnt_inc;
    logic [NumDomains-1:0]   ready_reg, done_reg, err_reg, clk_en_reg;
    logic [NumPlls-1:0]      pll_en_reg;
    logic                    busy_reg;
    logic [SrcW-1:0]         clk_sel_reg [NumDomains];
    logic [SrcW-1:0]         req_src     [NumDomains];

    logic [NumDomains-1:0]   arb_gnt;
    logic [DomW-1:0]         arb_idx;
    logic                    arb_valid;
    logic                    arb_en;

    logic [NumPlls-1:0]      pll_onehot;
    logic [NumPlls-1:0]      pll_used;
    logic [NumPlls-1:0][NumDomains-1:0] sel_match;
    logic                    lock_ok;
    logic                    src_bad, win_bad;

    // Arbitrate only in IDLE, and not in the cycle an accept pulse is out,
    // since the winner still holds its valid during that cycle.
    assign arb_en = (state_reg == IDLE) && (ready_reg == '0);

    carfield_clk_seq_rr #(
        .N    (NumDomains),
        .IdxW (DomW)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (arb_en),
        .req_i   (req_valid_i),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    for (genvar gi = 0; gi < NumDomains; gi++) begin : g_dom
        assign req_src[gi]                  = req_src_i[gi*SrcW +: SrcW];
        assign clk_sel_o[gi*SrcW +: SrcW]   = clk_sel_reg[gi];
    end

    // A PLL is in use while any domain mux selects it; the target PLL is decoded one-hot.
    for (genvar gi = 0; gi < NumPlls; gi++) begin : g_pll
        for (genvar gj = 0; gj < NumDomains; gj++) begin : g_use
            assign sel_match[gi][gj] = (clk_sel_reg[gj] == SrcW'(gi + 1));
        end
        assign pll_used[gi]   = |sel_match[gi];
        assign pll_onehot[gi] = (src_reg == SrcW'(gi + 1));
    end

    assign lock_ok = (src_reg == SrcW'(RefClkSrc)) || |(pll_lock_i & pll_onehot);
    assign src_bad = {1'b0, src_reg} > MaxSrc;
    assign win_bad = {1'b0, req_src[arb_idx]} > MaxSrc;
    assign cnt_inc = (cnt_reg == CntW'(CntMax)) ? cnt_reg : cnt_reg + 1'b1;

    assign req_ready_o = ready_reg;
    assign pll_en_o    = pll_en_reg;
    assign clk_en_o    = clk_en_reg;
    assign done_o      = done_reg;
    assign err_o       = err_reg;
    assign busy_o      = busy_reg;

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            dom_reg    <= '0;
            src_reg    <= '0;
            cnt_reg    <= '0;
            ready_reg  <= '0;
            done_reg   <= '0;
            err_reg    <= '0;
            clk_en_reg <= '1;
            pll_en_reg <= '0;
            busy_reg   <= 1'b0;
            for (int d = 0; d < int'(NumDomains); d++) clk_sel_reg[d] <= '0;
        end else begin
            ready_reg <= '0;
            done_reg  <= '0;
            err_reg   <= '0;
            unique case (state_reg)
                IDLE: begin
                    if (ready_reg != '0) begin
                        // Accepted request that needed no sequencing.
                        if (src_bad) err_reg[dom_reg]  <= 1'b1;
                        else         done_reg[dom_reg] <= 1'b1;
                    end else if (arb_valid) begin
                        ready_reg <= arb_gnt;
                        dom_reg   <= arb_idx;
                        src_reg   <= req_src[arb_idx];
                        if (!win_bad && req_src[arb_idx] != clk_sel_reg[arb_idx]) begin
                            state_reg <= GATE;
                            busy_reg  <= 1'b1;
                            cnt_reg   <= '0;
                        end
                    end
                end
                GATE: begin
                    // First GATE edge closes the gate and starts the PLL so lock overlaps gating.
                    if (cnt_reg == '0) begin
                        clk_en_reg[dom_reg] <= 1'b0;
                        pll_en_reg          <= pll_en_reg | pll_onehot;
                    end
                    if (cnt_reg == CntW'(GateCycles)) begin
                        state_reg <= LOCK;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                LOCK: begin
                    if (lock_ok) begin
                        state_reg            <= SWITCH;
                        clk_sel_reg[dom_reg] <= src_reg;
                        cnt_reg              <= '0;
                    end else if (32'(cnt_reg) + 1 >= LockTimeout) begin
                        state_reg <= FAIL;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                SWITCH: begin
                    if (32'(cnt_reg) + 1 >= SwitchCycles) begin
                        state_reg           <= UNGATE;
                        clk_en_reg[dom_reg] <= 1'b1;
                        done_reg[dom_reg]   <= 1'b1;
                        pll_en_reg          <= pll_en_reg & pll_used;
                    end else begin
                        cnt_reg <= cnt_inc;
                    end
                end
                FAIL: begin
                    // Mux untouched; drop the target PLL unless another domain relies on it.
                    state_reg           <= UNGATE;
                    clk_en_reg[dom_reg] <= 1'b1;
                    err_reg[dom_reg]    <= 1'b1;
                    pll_en_reg          <= pll_en_reg & pll_used;
                end
                UNGATE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carfield_clk_seq.sv
// Directed bench for carfield_clk_seq with a scoreboard of expected completions.
// Built with two PLLs so that source 3 is out of range and exercises the error path.
module tb_carfield_clk_seq;

    localparam int ND = 4;
    localparam int NP = 2;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [ND-1:0]  req_valid;
    logic [ND*SW-1:0] req_src;
    logic [ND-1:0]  req_ready;
    logic [NP-1:0]  pll_en;
    logic [NP-1:0]  pll_lock;
    logic [ND-1:0]  clk_en;
    logic [ND*SW-1:0] clk_sel;
    logic [ND-1:0]  done;
    logic [ND-1:0]  err;
    logic           busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int dom;
        int src;
        bit is_err;
        bit gates;
        int lat;
        bit pll_stable;
    } exp_t;

    exp_t exp_q[$];
    int   sel_model [ND];

    always #5 clk = ~clk;

    carfield_clk_seq #(
        .NumDomains   (ND),
        .NumPlls      (NP),
        .GateCycles   (8),
        .SwitchCycles (16),
        .LockTimeout  (4096)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_src_i   (req_src),
        .req_ready_o (req_ready),
        .pll_en_o    (pll_en),
        .pll_lock_i  (pll_lock),
        .clk_en_o    (clk_en),
        .clk_sel_o   (clk_sel),
        .done_o      (done),
        .err_o       (err),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ND*SW-1:0] model_sel();
        logic [ND*SW-1:0] v;
        v = '0;
        for (int d = 0; d < ND; d++) v[d*SW +: SW] = SW'(sel_model[d]);
        return v;
    endfunction

    function automatic logic [NP-1:0] model_pll();
        logic [NP-1:0] v;
        v = '0;
        for (int d = 0; d < ND; d++) if (sel_model[d] != 0) v[sel_model[d]-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [SW-1:0] sel_of(input int d);
        return clk_sel[d*SW +: SW];
    endfunction

    task automatic push(input int d, input int s, input bit e, input bit g, input int lat, input bit st);
        exp_t x;
        x.dom = d; x.src = s; x.is_err = e; x.gates = g; x.lat = lat; x.pll_stable = st;
        exp_q.push_back(x);
    endtask

    task automatic drive(input int d, input int s);
        req_src[d*SW +: SW] = SW'(s);
        req_valid[d] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_clk_en", clk_en, 4'hf);
        check("rst_clk_sel", clk_sel, 0);
        check("rst_pll_en", pll_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        for (int d = 0; d < ND; d++) sel_model[d] = 0;
        rst_n = 1'b1;
    endtask

    // Pops the next expected transaction and follows it from accept to completion.
    task automatic serve(input int budget);
        exp_t e;
        int t;
        logic [ND-1:0] rd;
        logic [NP-1:0] pll_start;
        bit stable;
        e = exp_q.pop_front();
        pll_start = pll_en;
        stable = 1'b1;
        t = 0;
        while (req_ready == '0 && t < 40) begin
            @(negedge clk);
            t++;
            if (pll_en !== pll_start) stable = 1'b0;
        end
        rd = req_ready;
        check("ready_dom", rd, 32'(1) << e.dom);
        req_valid[e.dom] = 1'b0;
        t = 0;
        while ((done | err) == '0 && t < budget) begin
            @(negedge clk);
            t++;
            if (pll_en !== pll_start) stable = 1'b0;
            if (t == 1) begin
                check("gate_en", clk_en[e.dom], !e.gates);
                if (e.gates && e.src != 0) check("pll_on", pll_en[e.src-1], 1);
            end
            if (t == 10 && e.gates && e.lat == 26) check("sel_switch", sel_of(e.dom), e.src);
        end
        check("done", done, e.is_err ? 0 : (32'(1) << e.dom));
        check("err", err, e.is_err ? (32'(1) << e.dom) : 0);
        check("latency", t, e.lat);
        if (!e.is_err) sel_model[e.dom] = e.src;
        check("clk_en_all", clk_en, 4'hf);
        check("clk_sel", clk_sel, model_sel());
        check("pll_en", pll_en, model_pll());
        if (e.pll_stable) check("pll_stable", stable, 1);
        $display("txn dom=%0d src=%0d err=%0b latency=%0d pll_en=%b clk_sel=%h",
                 e.dom, e.src, e.is_err, t, pll_en, clk_sel);
        @(negedge clk);
    endtask

    initial begin
        int t;
        rst_n     = 1'b0;
        req_valid = '0;
        req_src   = '0;
        pll_lock  = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // Host to PLL 0 with lock already high.
        pll_lock = 2'b01;
        push(0, 1, 0, 1, 26, 0);
        drive(0, 1);
        serve(100);

        // Periph to PLL 1 whose lock never rises: timeout.
        push(1, 2, 1, 1, 4106, 0);
        drive(1, 2);
        serve(5000);

        // All four domains ask for PLL 0 together after a fresh reset.
        do_reset();
        push(0, 1, 0, 1, 26, 0);
        push(1, 1, 0, 1, 26, 1);
        push(2, 1, 0, 1, 26, 1);
        push(3, 1, 0, 1, 26, 1);
        for (int d = 0; d < ND; d++) drive(d, 1);
        for (int k = 0; k < ND; k++) serve(100);

        // Domain 2: to PLL 1, then an out-of-range source, then its current source.
        pll_lock = 2'b11;
        push(2, 2, 0, 1, 26, 0);
        drive(2, 2);
        serve(100);
        push(2, 3, 1, 0, 1, 1);
        drive(2, 3);
        serve(100);
        push(2, 2, 0, 0, 1, 1);
        drive(2, 2);
        serve(100);

        // Move domains 0, 1, 3 back to the reference; the last releases PLL 0.
        push(0, 0, 0, 1, 26, 0);
        drive(0, 0);
        serve(100);
        push(1, 0, 0, 1, 26, 0);
        drive(1, 0);
        serve(100);
        push(3, 0, 0, 1, 26, 0);
        drive(3, 0);
        serve(100);

        // Reset in the middle of a SWITCH phase.
        drive(0, 1);
        t = 0;
        while (req_ready == '0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("ready_rst_case", req_ready, 4'b0001);
        req_valid[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_in_switch", busy, 1);
        check("sel_in_switch", sel_of(0), 1);
        $display("txn reset during SWITCH");
        do_reset();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
